// File: rtl/binary_add_pkg.sv
// ---------------------------------------------------------------------------
// binary_add_pkg
// Shared types and helpers for the binary_add_arbiter block.
//   state_t   : scheduler FSM states
//   DEFAULT_W : default operand/result width of the shared adder
//   clog2     : elaboration-time ceiling log2, used to size requester IDs
// ---------------------------------------------------------------------------
package binary_add_pkg;

    localparam int DEFAULT_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Smallest n with 2**n >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/binary_add_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches the request vector upward
// from the pointer position, wrapping from NUM_REQ-1 back to 0, and reports
// the first set bit. The pointer register lives in the parent.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDW      search start position
//   grant   out NUM_REQ  one-hot grant (zero when no request)
//   idx     out IDW      binary index of the grant
//   any_req out 1        at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
    import binary_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any_req
);

    int pos;

    // Walk offsets from the farthest to the nearest so that the nearest
    // requester at or above the pointer is the last (winning) assignment.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        pos     = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = (int'(ptr) + off) % NUM_REQ;
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
                any_req    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/binary_add_arbiter.sv
// ---------------------------------------------------------------------------
// binary_add_arbiter
// Round-robin scheduler sharing one external registered adder between
// NUM_REQ requesters. One operation is in flight at a time; the result is
// returned on a single response channel tagged with the requester index.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for any req_valid; grant is combinational, handshake at edge
// ISSUE | add_en high for one cycle with the latched operands on add_a/add_b
// WAIT  | down-counting the adder latency; add_s captured at terminal count
// RESP  | rsp_valid high, held until rsp_ready
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or 0)
//   req_a/req_b              packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/rsp_id          sum mod 2^W and owning requester
//   add_a/add_b/add_en       drive the shared adder
//   add_s                    shared adder result
//   busy                     high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module binary_add_arbiter
    import binary_add_pkg::*;
#(
    parameter int W           = DEFAULT_W,
    parameter int NUM_REQ     = 4,
    parameter int IDW         = clog2(NUM_REQ),
    parameter int ADD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_en,
    input  logic [W-1:0]         add_s,
    output logic                 busy
);

    localparam int CNT_W = 3;

    state_t             state;
    state_t             state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     owner_id;
    logic [IDW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_req;
    logic [CNT_W-1:0]   wait_cnt;
    logic               take;
    logic               capture;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .idx     (grant_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is gated by rst so that no grant is visible while reset is
    // held: the state already reads IDLE then, which would otherwise expose
    // a combinational grant.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        capture    = 1'b0;
        req_ready  = '0;
        add_en     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !rst) begin
                    req_ready  = grant;
                    take       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                add_en     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: operand latch, pointer, latency timer and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner_id  <= '0;
            add_a     <= '0;
            add_b     <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (take) begin
                add_a    <= req_a[int'(grant_idx)*W +: W];
                add_b    <= req_b[int'(grant_idx)*W +: W];
                owner_id <= grant_idx;
                rr_ptr   <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end

            // Timer loads on ISSUE so that terminal count lands on the first
            // cycle add_s carries the result.
            if (state == ISSUE) begin
                wait_cnt <= CNT_W'(ADD_LATENCY - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= add_s;
                rsp_id    <= owner_id;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_binary_add_arbiter.sv
module tb_binary_add_arbiter;

    localparam int W  = 11;
    localparam int N  = 4;
    localparam int LAT = 1;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [1:0]    rsp_id;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_en;
    logic [W-1:0]  add_s;
    logic          busy;

    // second instance with a 3-stage adder
    logic [N-1:0]   v3;
    logic [N-1:0]   rdy3;
    logic [N*W-1:0] a3;
    logic [N*W-1:0] b3;
    logic           rv3;
    logic           rr3;
    logic [W-1:0]   rd3;
    logic [1:0]     ri3;
    logic [W-1:0]   aa3;
    logic [W-1:0]   ab3;
    logic           ae3;
    logic [W-1:0]   as3;
    logic           busy3;

    int n_cmp = 0;
    int n_err = 0;

    int q_id[$];
    int q_data[$];

    binary_add_arbiter #(.W(W), .NUM_REQ(N), .ADD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_s(add_s),
        .busy(busy)
    );

    binary_add_arbiter #(.W(W), .NUM_REQ(N), .ADD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_data(rd3), .rsp_id(ri3),
        .add_a(aa3), .add_b(ab3), .add_en(ae3), .add_s(as3),
        .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // adder models: 1-stage for dut, 3-stage for dut3
    logic [W-1:0] s1_r;
    logic [W-1:0] p1, p2, p3;
    always @(posedge clk) begin
        if (add_en) s1_r <= add_a + add_b;
        if (ae3) p1 <= aa3 + ab3;
        p2 <= p1;
        p3 <= p2;
    end
    assign add_s = s1_r;
    assign as3   = p3;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: an operation is described by its age in
    // cycles since the handshake; outputs follow from the age alone.
    bit           m_busy = 0;
    int           m_age = 0;
    int           m_id = 0;
    int           m_a = 0;
    int           m_b = 0;
    int           m_ptr = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int           g;
        bit           found;
        exp_ready = '0;
        g = 0;
        found = 0;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_add_en", add_en, 0);
            chk("rst_busy", busy, 0);
            m_busy = 0;
            m_ptr  = 0;
        end else begin
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        found = 1;
                        g = (m_ptr + k) % N;
                    end
                end
                if (found) exp_ready[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, m_busy);
            chk("add_en", add_en, (m_busy && m_age == 1) ? 1 : 0);
            chk("rsp_valid", rsp_valid, (m_busy && m_age >= 2 + LAT) ? 1 : 0);
            if (m_busy) begin
                chk("add_a", add_a, m_a);
                chk("add_b", add_b, m_b);
            end
            if (m_busy && m_age >= 2 + LAT) begin
                chk("rsp_data", rsp_data, (m_a + m_b) % 2048);
                chk("rsp_id", rsp_id, m_id);
            end
            if (rsp_valid && rsp_ready) begin
                q_id.push_back(int'(rsp_id));
                q_data.push_back(int'(rsp_data));
            end
            if (m_busy) begin
                if (m_age >= 2 + LAT && rsp_ready) m_busy = 0;
                else m_age++;
            end else if (found) begin
                m_busy = 1;
                m_age  = 1;
                m_id   = g;
                m_a    = int'(req_a[g*W +: W]);
                m_b    = int'(req_b[g*W +: W]);
                m_ptr  = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic run_op(input int i, input int a, input int b);
        set_op(i, a, b);
        req_valid = N'(1 << i);
        step();
        req_valid = '0;
        repeat (3) step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
        chk({tag, "_add_en"}, add_en, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int seq_a[5];
        int seq_b[3];
        seq_a = '{0, 1, 2, 3, 0};
        seq_b = '{1, 3, 1};

        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        v3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // fairness with all four requesting
        q_id.delete();
        for (int i = 0; i < N; i++) set_op(i, 10 * (i + 1), i);
        req_valid = 4'b1111;
        repeat (20) step();
        req_valid = '0;
        chk("fair_count", q_id.size(), 5);
        for (int k = 0; k < 5 && k < q_id.size(); k++) chk("fair_seq", q_id[k], seq_a[k]);

        // 1010 pattern: pointer is at 1
        q_id.delete();
        req_valid = 4'b1010;
        repeat (12) step();
        req_valid = '0;
        chk("alt_count", q_id.size(), 3);
        for (int k = 0; k < 3 && k < q_id.size(); k++) chk("alt_seq", q_id[k], seq_b[k]);

        // single request with cycle-accurate literal checks
        set_op(0, 100, 23);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("single_add_en", add_en, 1);
        chk("single_add_a", add_a, 100);
        chk("single_add_b", add_b, 23);
        step();
        chk("single_rsp_early", rsp_valid, 0);
        step();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_data", rsp_data, 123);
        chk("single_rsp_id", rsp_id, 0);
        step();
        chk("single_done", rsp_valid, 0);

        // modular wrap
        q_data.delete();
        run_op(0, 2047, 1);
        chk("wrap_2047_1", (q_data.size() > 0) ? q_data[$] : -1, 0);
        q_data.delete(); q_id.delete();
        run_op(1, 1500, 1000);
        chk("wrap_1500_1000", (q_data.size() > 0) ? q_data[$] : -1, 452);
        chk("wrap_id", (q_id.size() > 0) ? q_id[$] : -1, 1);

        // backpressure with requester 2 kept valid
        set_op(2, 300, 400);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        repeat (3) step();
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 700);
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        chk("bp_hold_last", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        chk("bp_regrant", req_ready, 4'b0100);
        chk("bp_rsp_drop", rsp_valid, 0);
        step();
        req_valid = '0;
        repeat (3) step();

        // reset during WAIT
        set_op(3, 5, 6);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        chk("mid_busy", busy, 1);
        q_id.delete();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        check_zero("rst_mid");
        step();
        check_zero("rst_hold");
        rst = 1'b0;
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (3) step();
        chk("post_rst_count", q_id.size(), 1);
        chk("post_rst_id", (q_id.size() > 0) ? q_id[0] : -1, 0);

        // ADD_LATENCY=3 instance
        a3[W-1:0] = 11'd7;
        b3[W-1:0] = 11'd8;
        v3 = 4'b0001;
        #1;
        chk("l3_ready", rdy3, 4'b0001);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                v3 = '0;
                chk("l3_busy", busy3, 1);
            end
            chk("l3_rsp_valid", rv3, (k == 5) ? 1 : 0);
        end
        chk("l3_rsp_data", rd3, 15);
        chk("l3_rsp_id", ri3, 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
